// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store client and data_mem_ctrl.
// The master drives requests and accepts responses; the slave is the memory controller.
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller: byte/half/word loads and stores
// with a fixed access latency, alignment/range checking and response backpressure.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus,
    output logic            busy
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          a_we;
    logic [1:0]    a_size;
    logic          a_signed;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic          a_err;
    logic          commit;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   lane;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   wdata_al;

    assign accept = req_ready_q && bus.req_valid;

    // In IDLE the live request is used so LATENCY=1 can commit on the acceptance edge.
    always_comb begin
        if (state_q == IDLE) begin
            a_we     = bus.req_we;
            a_size   = bus.req_size;
            a_signed = bus.req_signed;
            a_addr   = bus.req_addr;
            a_wdata  = bus.req_wdata;
        end else begin
            a_we     = we_q;
            a_size   = size_q;
            a_signed = signed_q;
            a_addr   = addr_q;
            a_wdata  = wdata_q;
        end
    end

    always_comb begin
        a_err = 1'b0;
        if (a_size == 2'd3)                              a_err = 1'b1;
        if (a_size == 2'd1 && a_addr[0])                 a_err = 1'b1;
        if (a_size == 2'd2 && a_addr[1:0] != 2'b00)      a_err = 1'b1;
        if ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS))   a_err = 1'b1;
    end

    // WAIT lasts LATENCY-1 cycles; the edge on which the count reaches zero enters RESP.
    assign commit = rst && (
        (state_q == IDLE && accept && !a_err && LATENCY == 1) ||
        (state_q == WAIT && cnt_q == 4'd1));

    assign word_idx = a_addr[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign lane     = rd_word >> {a_addr[1:0], 3'b000};

    always_comb begin
        ld_data  = rd_word;
        be       = 4'b1111;
        wdata_al = a_wdata;
        case (a_size)
            2'd0: begin
                ld_data  = a_signed ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
                be       = 4'b0001 << a_addr[1:0];
                wdata_al = {4{a_wdata[7:0]}};
            end
            2'd1: begin
                ld_data  = a_signed ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
                be       = 4'b0011 << {a_addr[1], 1'b0};
                wdata_al = {2{a_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d        = bus.req_we;
                    size_d      = bus.req_size;
                    signed_d    = bus.req_signed;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (a_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (LATENCY == 1) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = a_we ? '0 : ld_data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = a_we ? '0 : ld_data;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Array carries no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && a_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (LATENCY=2, DEPTH_WORDS=1024).
module tb_data_mem_ctrl;
    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transaction; lat = cycle index after acceptance in which resp_valid is seen.
    task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int unsigned lat, output logic [31:0] rd, output logic er);
        int unsigned n;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata); end
        checks++; if (bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_word();
        int unsigned lat; logic [31:0] rd; logic er;
        access(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, lat, rd, er);
        checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, rd, er);
        checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL lw_data got=%h exp=12345678", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", er); end
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL post_handshake got=%b/%b exp=1/0", bus.req_ready, bus.resp_valid); end
    endtask

    task automatic test_byte();
        int unsigned lat; logic [31:0] rd; logic er;
        access(1'b1, 2'd0, 1'b0, 32'h1, 32'hDEAD_00AB, lat, rd, er);
        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h1234_AB78) begin failures++; $display("FAIL sb_merge got=%h exp=1234ab78", rd); end
        access(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFF_FFAB) begin failures++; $display("FAIL lb got=%h exp=ffffffab", rd); end
        access(1'b0, 2'd0, 1'b0, 32'h1, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h0000_00AB) begin failures++; $display("FAIL lbu got=%h exp=000000ab", rd); end
        access(1'b0, 2'd0, 1'b1, 32'h3, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h0000_0012) begin failures++; $display("FAIL lb_lane3 got=%h exp=00000012", rd); end
    endtask

    task automatic test_half();
        int unsigned lat; logic [31:0] rd; logic er;
        access(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344, lat, rd, er);
        access(1'b1, 2'd1, 1'b0, 32'h6, 32'hCAFE_8001, lat, rd, er);
        access(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", rd); end
        access(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h0000_8001) begin failures++; $display("FAIL lhu got=%h exp=00008001", rd); end
        access(1'b0, 2'd2, 1'b1, 32'h4, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h8001_3344) begin failures++; $display("FAIL sh_merge got=%h exp=80013344", rd); end
        access(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h0000_3344) begin failures++; $display("FAIL lh_positive got=%h exp=00003344", rd); end
        access(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_lane3_neg got=%h exp=ffffff80", rd); end
    endtask

    task automatic test_errors();
        int unsigned lat; logic [31:0] rd; logic er;
        logic        ev_we   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  ev_sz   [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [31:0] ev_addr [4] = '{32'h2, 32'h3, 32'h0, 32'd4096};
        for (int i = 0; i < 4; i++) begin
            access(ev_we[i], ev_sz[i], 1'b0, ev_addr[i], 32'hFFFF_FFFF, lat, rd, er);
            checks++; if (lat !== 1) begin failures++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
            checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL err%0d_resp got=%b/%h exp=1/0", i, er, rd); end
        end
        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h1234_AB78) begin failures++; $display("FAIL err_mem0 got=%h exp=1234ab78", rd); end
        access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h8001_3344) begin failures++; $display("FAIL err_mem4 got=%h exp=80013344", rd); end
    endtask

    task automatic test_backpressure();
        int unsigned n; int unsigned lat; logic [31:0] rd; logic er;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0; bus.req_addr = 32'h0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", n); end
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/1234ab78", i, bus.resp_valid, bus.resp_rdata); end
            checks++; if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_ready%0d got=%b/%b exp=0/1", i, bus.req_ready, busy); end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got=%b/%b/%b exp=0/1/0", bus.resp_valid, bus.req_ready, busy); end
        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h1234_AB78) begin failures++; $display("FAIL bp_ignored_store got=%h exp=1234ab78", rd); end
    endtask

    task automatic test_reset_in_wait();
        int unsigned n; int unsigned lat; logic [31:0] rd; logic er;
        access(1'b1, 2'd2, 1'b0, 32'h8, 32'h0BAD_F00D, lat, rd, er);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h8; bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b exp=1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL wait_reset_clear got=%b/%b/%b/%h exp=0/0/0/0", busy, bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL wait_abort_store got=%h exp=0badf00d", rd); end
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'hC; bus.req_wdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        rst = 1'b0;
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || n !== 2) begin failures++; $display("FAIL resp_reset got=%b/%0d exp=0/2", bus.resp_valid, n); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, lat, rd, er);
        checks++; if (rd !== 32'h1357_9BDF) begin failures++; $display("FAIL resp_reset_store_kept got=%h exp=13579bdf", rd); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array; the word index is addr[31:2].
REQ-002 Parameter LATENCY, default 2, legal range 1-15: cycles from request acceptance to resp_valid for a legal access.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, 1: a request is presented.
REQ-006 Port req_ready, output, 1: the block can accept a request this cycle.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_size, input, 2: access size; 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 Port req_signed, input, 1: sign-extend a load result (lb/lh); 0 = zero-extend (lbu/lhu).
REQ-010 Port req_addr, input, 32: byte address.
REQ-011 Port req_wdata, input, 32: store data; the low byte or half is used for sb/sh.
REQ-012 Port resp_valid, output, 1: a response is pending.
REQ-013 Port resp_ready, input, 1: the consumer accepts the response.
REQ-014 Port resp_rdata, output, 32: load result; 0 for stores and errors.
REQ-015 Port resp_err, output, 1: the access was misaligned, out of range or of illegal size.
REQ-016 Port busy, output, 1: the FSM is not in IDLE.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 Acceptance occurs on a rising edge with req_valid=1 and req_ready=1; the block latches req_we, req_size, req_signed, req_addr and req_wdata.
REQ-019 An access is an error if any of these holds:
- req_size = 3
- half access with addr[0] = 1
- word access with addr[1:0] != 0
- addr[31:2] >= DEPTH_WORDS
REQ-020 Error request: IDLE -> RESP on the acceptance edge; resp_valid=1 the next cycle with resp_err=1 and resp_rdata=0; the memory is not modified.
REQ-021 Legal request: IDLE -> WAIT and a 4-bit counter loads LATENCY-1; WAIT decrements it each cycle; at count 0, WAIT -> RESP; resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-022 If LATENCY = 1, a legal request goes IDLE -> RESP directly, through the same commit edge.
REQ-023 Stores commit on the edge entering RESP:
- byte lanes are little-endian (addr[1:0] = 0 selects bits 7:0)
- sb writes one lane and sh writes lanes {addr[1],0}+1..{addr[1],0}
- unselected lanes are preserved
REQ-024 Loads read the array on the edge entering RESP:
- extract the selected lane(s)
- extend to 32 bits per req_signed
- word loads ignore req_signed
REQ-025 In RESP, resp_valid, resp_rdata and resp_err hold stable until resp_ready=1; on that edge the FSM returns to IDLE and resp_valid falls.
REQ-026 A new request is accepted no earlier than the cycle after the response handshake (no overlap); req_valid in other states is ignored.
REQ-027 The block never issues a second commit for one request, whatever resp_ready backpressure is applied.
REQ-028 The array has no reset; initial contents come from $readmemh on the internal array mem, indexed by word.

Reset
REQ-029 rst=0 forces asynchronously:
- state = IDLE, counter = 0
- resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0
- req_ready = 1 after release
REQ-030 Reset during WAIT aborts the access: a store not yet committed is not written, and the array is otherwise untouched.
REQ-031 Reset during RESP discards the pending response; an already committed store remains.

Verification
REQ-032 Scenario: LATENCY=2; sw 0x12345678 @0x0; then lw @0x0 -> resp_valid 2 cycles after each acceptance, resp_rdata=0x12345678, resp_err=0.
REQ-033 Scenario: after REQ-032:
- sb 0xAB @0x1, then lw @0x0 -> 0x1234AB78
- lb @0x1 -> 0xFFFFFFAB
- lbu @0x1 -> 0x000000AB
REQ-034 Scenario: sh 0x8001 @0x6, then:
- lh @0x6 -> 0xFFFF8001
- lhu @0x6 -> 0x00008001
- lw @0x4 -> upper half 0x8001, lower half unchanged
REQ-035 Scenario: each of these gives resp_err=1 one cycle after acceptance and leaves the memory unchanged:
- lw @0x2
- sh @0x3
- req_size=3
- sw @(DEPTH_WORDS*4)
REQ-036 Scenario: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready=0, and a second req_valid is ignored; then resp_ready=1 -> IDLE next cycle.
REQ-037 Scenario: assert rst=0 in WAIT of sw 0xDEADBEEF @0x8 -> outputs clear immediately, and a later lw @0x8 returns the old value.
